// File: rtl/gb_pkg.sv
// Shared constants, palette and joypad layout for the Game Boy display shell.
package gb_pkg;

    // 720x480 progressive timing (one pixel per clock)
    localparam logic [9:0] H_ACTIVE = 10'd720;
    localparam logic [9:0] H_TOTAL  = 10'd858;
    localparam logic [9:0] H_LAST   = 10'd857;
    localparam logic [9:0] HS_START = 10'd736;
    localparam logic [9:0] HS_END   = 10'd797;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_TOTAL  = 10'd525;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] VS_START = 10'd489;
    localparam logic [9:0] VS_END   = 10'd494;

    // 160x144 LCD scaled 3x, placed inside the active area
    localparam logic [9:0] WIN_X0   = 10'd120;
    localparam logic [9:0] WIN_X1   = 10'd599;
    localparam logic [9:0] WIN_Y0   = 10'd24;
    localparam logic [9:0] WIN_Y1   = 10'd455;
    localparam logic [1:0] SCALE_M1 = 2'd2;

    // DMG-style green palette indexed by shade
    localparam logic [23:0] PALETTE [4] = '{
        24'h9BBC0F,
        24'h8BAC0F,
        24'h306230,
        24'h0F380F
    };

    // Button layout, MSB first, matching the regA pressed mask
    typedef struct packed {
        logic start;
        logic select;
        logic b;
        logic a;
        logic down;
        logic up;
        logic left;
        logic right;
    } joypad_t;

    // Checkerboard shade from scrolled LCD coordinates (8-bit wrap adds)
    function automatic logic [1:0] bg_shade(input logic [7:0] gx, input logic [7:0] gy,
                                            input logic [7:0] scx, input logic [7:0] scy);
        logic [7:0] x;
        logic [7:0] y;
        x = gx + scx;
        y = gy + scy;
        return {x[4] ^ y[4], x[3] ^ y[3]};
    endfunction

endpackage

// File: rtl/gb_video_timing.sv
// Pixel/line counters, sync and enable levels, and LCD coordinate generation.
// All outputs are combinational and aligned with the counter values.
module gb_video_timing
    import gb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       active_o,
    output logic       hs_n_o,
    output logic       vs_n_o,
    output logic       in_win_o,
    output logic [7:0] gx_o,
    output logic [7:0] gy_o
);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic [1:0] sx_q, sx_d;
    logic [1:0] sy_q, sy_d;
    logic [7:0] gx_q, gx_d;
    logic [7:0] gy_q, gy_d;

    // Next-state for counters; gx/gy advance every third pixel/line so no divider is needed
    always_comb begin
        h_d  = h_q + 10'd1;
        v_d  = v_q;
        sx_d = sx_q;
        gx_d = gx_q;
        sy_d = sy_q;
        gy_d = gy_q;

        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end

        // Horizontal sub-counter restarts so that the first window pixel is gx=0
        if (h_d == WIN_X0) begin
            sx_d = '0;
            gx_d = '0;
        end else if (sx_q == SCALE_M1) begin
            sx_d = '0;
            gx_d = gx_q + 8'd1;
        end else begin
            sx_d = sx_q + 2'd1;
        end

        // Vertical sub-counter steps once per line, restarting on the first window line
        if (h_q == H_LAST) begin
            if (v_d == WIN_Y0) begin
                sy_d = '0;
                gy_d = '0;
            end else if (sy_q == SCALE_M1) begin
                sy_d = '0;
                gy_d = gy_q + 8'd1;
            end else begin
                sy_d = sy_q + 2'd1;
            end
        end
    end

    // Counter state registers with synchronous reset to the top-left of the frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q  <= '0;
            v_q  <= '0;
            sx_q <= '0;
            sy_q <= '0;
            gx_q <= '0;
            gy_q <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            sx_q <= sx_d;
            sy_q <= sy_d;
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    assign h_o      = h_q;
    assign v_o      = v_q;
    assign gx_o     = gx_q;
    assign gy_o     = gy_q;
    assign active_o = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
    assign hs_n_o   = !((h_q >= HS_START) && (h_q <= HS_END));
    assign vs_n_o   = !((v_q >= VS_START) && (v_q <= VS_END));
    assign in_win_o = (h_q >= WIN_X0) && (h_q <= WIN_X1) &&
                      (v_q >= WIN_Y0) && (v_q <= WIN_Y1);

endmodule

// File: rtl/gameboy_top.sv
// Game Boy display shell: video output, joypad synchronisation and the
// per-frame debug register updates that scroll the background.
module gameboy_top
    import gb_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        joypad_up,
    input  logic        joypad_down,
    input  logic        joypad_left,
    input  logic        joypad_right,
    input  logic        joypad_a,
    input  logic        joypad_b,
    input  logic        joypad_start,
    input  logic        joypad_select,
    output logic        HDMI_TX_DE,
    output logic        HDMI_TX_HS,
    output logic        HDMI_TX_VS,
    output logic [23:0] HDMI_TX_D,
    output logic [7:0]  regA,
    output logic [7:0]  regB,
    output logic [7:0]  regC,
    output logic [7:0]  regD,
    output logic [7:0]  regE,
    output logic [7:0]  regF,
    output logic [7:0]  regH,
    output logic [7:0]  regL
);

    logic [9:0] h;
    logic [9:0] v;
    logic       active;
    logic       hs_n;
    logic       vs_n;
    logic       in_win;
    logic [7:0] gx;
    logic [7:0] gy;

    gb_video_timing u_timing (
        .clk_i    (cpu_clk),
        .rst_i    (rst),
        .h_o      (h),
        .v_o      (v),
        .active_o (active),
        .hs_n_o   (hs_n),
        .vs_n_o   (vs_n),
        .in_win_o (in_win),
        .gx_o     (gx),
        .gy_o     (gy)
    );

    // ---------------- joypad ----------------
    joypad_t raw;
    joypad_t sync1_q;
    joypad_t sync2_q;
    joypad_t pressed;

    assign raw = {joypad_start, joypad_select, joypad_b, joypad_a,
                  joypad_down, joypad_up, joypad_left, joypad_right};
    assign pressed = ~sync2_q;

    // Two-flop synchroniser; idles released (high) out of reset
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // ---------------- debug registers ----------------
    logic       frame_upd;
    logic [7:0] regA_q, regA_d;
    logic [7:0] regB_q, regB_d;
    logic [7:0] regC_q, regC_d;
    logic [7:0] regD_q, regD_d;
    logic [7:0] regE_q, regE_d;
    logic [7:0] regF_q, regF_d;
    logic [15:0] hl_q, hl_d;
    logic       prev_start_q, prev_start_d;
    logic       prev_a_q, prev_a_d;

    // Single-cycle strobe on entry into vertical blanking
    assign frame_upd = (h == 10'd0) && (v == V_ACTIVE);

    // Per-frame register update from the synchronised button state
    always_comb begin
        regA_d       = regA_q;
        regB_d       = regB_q;
        regC_d       = regC_q;
        regD_d       = regD_q;
        regE_d       = regE_q;
        regF_d       = regF_q;
        hl_d         = hl_q;
        prev_start_d = prev_start_q;
        prev_a_d     = prev_a_q;

        if (frame_upd) begin
            regA_d = pressed;

            case ({pressed.right, pressed.left})
                2'b10:   regC_d = regC_q + 8'd1;
                2'b01:   regC_d = regC_q - 8'd1;
                default: regC_d = regC_q;
            endcase

            case ({pressed.down, pressed.up})
                2'b10:   regD_d = regD_q + 8'd1;
                2'b01:   regD_d = regD_q - 8'd1;
                default: regD_d = regD_q;
            endcase

            if (pressed.start && !prev_start_q) regE_d = regE_q + 8'd1;
            if (pressed.a && !prev_a_q)         regB_d = regB_q + 8'd1;

            hl_d         = hl_q + 16'd1;
            regF_d       = {(pressed == '0), 7'b0};
            prev_start_d = pressed.start;
            prev_a_d     = pressed.a;
        end
    end

    // Debug register state; regF reset value reflects "no buttons pressed"
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            regA_q       <= '0;
            regB_q       <= '0;
            regC_q       <= '0;
            regD_q       <= '0;
            regE_q       <= '0;
            regF_q       <= 8'h80;
            hl_q         <= '0;
            prev_start_q <= 1'b0;
            prev_a_q     <= 1'b0;
        end else begin
            regA_q       <= regA_d;
            regB_q       <= regB_d;
            regC_q       <= regC_d;
            regD_q       <= regD_d;
            regE_q       <= regE_d;
            regF_q       <= regF_d;
            hl_q         <= hl_d;
            prev_start_q <= prev_start_d;
            prev_a_q     <= prev_a_d;
        end
    end

    assign regA = regA_q;
    assign regB = regB_q;
    assign regC = regC_q;
    assign regD = regD_q;
    assign regE = regE_q;
    assign regF = regF_q;
    assign regH = hl_q[15:8];
    assign regL = hl_q[7:0];

    // ---------------- video output ----------------
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [23:0] pix_q, pix_d;

    // Pixel colour: scrolled checkerboard inside the window, black elsewhere, zero in blanking
    always_comb begin
        de_d  = active;
        hs_d  = hs_n;
        vs_d  = vs_n;
        pix_d = '0;
        if (active && in_win) begin
            pix_d = PALETTE[bg_shade(gx, gy, regC_q, regD_q)];
        end
    end

    // Output stage: all video signals registered together, one cycle behind the counters
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            de_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            pix_q <= '0;
        end else begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            pix_q <= pix_d;
        end
    end

    assign HDMI_TX_DE = de_q;
    assign HDMI_TX_HS = hs_q;
    assign HDMI_TX_VS = vs_q;
    assign HDMI_TX_D  = pix_q;

endmodule

// File: tb/tb_gameboy_top.sv
// Self-checking bench for gameboy_top: full-frame video check plus per-frame
// register checks against a frame-level reference model.
module tb_gameboy_top;

    localparam int FRAME    = 858 * 525;
    localparam int UPD_T    = 858 * 480;

    logic        cpu_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [7:0]  btn     = 8'h00;  // pressed mask: 0 right,1 left,2 up,3 down,4 a,5 b,6 select,7 start
    logic        de, hs, vs;
    logic [23:0] d;
    logic [7:0]  rA, rB, rC, rD, rE, rF, rH, rL;

    int vectors    = 0;
    int miscompares = 0;
    int t          = -1;   // cycle index: outputs sampled now reflect counter time t

    // reference model state
    logic [7:0]  mA, mB, mC, mD, mE, mF;
    logic [15:0] mHL;
    logic        m_prev_start, m_prev_a;
    logic [23:0] pal [4];

    always #5 cpu_clk = ~cpu_clk;

    gameboy_top dut (
        .cpu_clk       (cpu_clk),
        .rst           (rst),
        .joypad_up     (~btn[2]),
        .joypad_down   (~btn[3]),
        .joypad_left   (~btn[1]),
        .joypad_right  (~btn[0]),
        .joypad_a      (~btn[4]),
        .joypad_b      (~btn[5]),
        .joypad_start  (~btn[7]),
        .joypad_select (~btn[6]),
        .HDMI_TX_DE    (de),
        .HDMI_TX_HS    (hs),
        .HDMI_TX_VS    (vs),
        .HDMI_TX_D     (d),
        .regA          (rA),
        .regB          (rB),
        .regC          (rC),
        .regD          (rD),
        .regE          (rE),
        .regF          (rF),
        .regH          (rH),
        .regL          (rL)
    );

    task automatic model_reset();
        mA = 8'h00; mB = 8'h00; mC = 8'h00; mD = 8'h00; mE = 8'h00; mF = 8'h80;
        mHL = 16'h0000; m_prev_start = 1'b0; m_prev_a = 1'b0;
    endtask

    task automatic model_update();
        mA = btn;
        if (btn[0] && !btn[1]) mC = mC + 8'd1;
        else if (btn[1] && !btn[0]) mC = mC - 8'd1;
        if (btn[3] && !btn[2]) mD = mD + 8'd1;
        else if (btn[2] && !btn[3]) mD = mD - 8'd1;
        if (btn[7] && !m_prev_start) mE = mE + 8'd1;
        if (btn[4] && !m_prev_a) mB = mB + 8'd1;
        m_prev_start = btn[7];
        m_prev_a     = btn[4];
        mHL = mHL + 16'd1;
        mF  = (btn == 8'h00) ? 8'h80 : 8'h00;
    endtask

    // advance one clock; model registers follow the frame-update instant
    task automatic tick();
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        t++;
        if (t >= 0 && (t % FRAME) == UPD_T) model_update();
    endtask

    task automatic run_to_update();
        do tick(); while ((t % FRAME) != UPD_T);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({de, hs, vs, d} !== {1'b0, 1'b1, 1'b1, 24'h0}) begin
            miscompares++;
            $display("FAIL reset_video: got de=%b hs=%b vs=%b d=%h want 0 1 1 000000", de, hs, vs, d);
        end
        vectors++;
        if ({rA, rB, rC, rD, rE, rF, rH, rL} !== {mA, mB, mC, mD, mE, mF, mHL}) begin
            miscompares++;
            $display("FAIL reset_regs: got %h %h %h %h %h %h %h %h want %h %h %h %h %h %h %h",
                     rA, rB, rC, rD, rE, rF, rH, rL, mA, mB, mC, mD, mE, mF, mHL);
        end
        rst = 1'b0;
        t = -1;
        tick();
        vectors++;
        if (de !== 1'b1) begin
            miscompares++;
            $display("FAIL first_de: got %b want 1 one cycle after release", de);
        end
    endtask

    task automatic test_frame();
        int h, v, gx, gy, sx, sy, sh;
        int de_total, line_de, line_hs, vs_lines;
        logic e_de, e_hs, e_vs;
        logic [23:0] e_d;
        de_total = 0; line_de = 0; line_hs = 0; vs_lines = 0;
        for (int i = 0; i < FRAME; i++) begin
            h = t % 858;
            v = (t / 858) % 525;
            e_de = (h < 720) && (v < 480);
            e_hs = !(h >= 736 && h <= 797);
            e_vs = !(v >= 489 && v <= 494);
            e_d  = 24'h0;
            if (e_de && h >= 120 && h < 600 && v >= 24 && v < 456) begin
                gx = (h - 120) / 3;
                gy = (v - 24) / 3;
                sx = (gx + int'(mC)) % 256;
                sy = (gy + int'(mD)) % 256;
                sh = (((sx / 16) % 2) ^ ((sy / 16) % 2)) * 2 + (((sx / 8) % 2) ^ ((sy / 8) % 2));
                e_d = pal[sh];
            end
            vectors++;
            if ({de, hs, vs, d} !== {e_de, e_hs, e_vs, e_d}) begin
                miscompares++;
                $display("FAIL video h=%0d v=%0d: got de=%b hs=%b vs=%b d=%h want %b %b %b %h",
                         h, v, de, hs, vs, d, e_de, e_hs, e_vs, e_d);
            end
            if (h == 120 && v == 24) begin
                vectors++;
                if (d !== 24'h9BBC0F) begin
                    miscompares++;
                    $display("FAIL pix_origin: got %h want 9bbc0f", d);
                end
            end
            if (h == 144 && v == 24) begin
                vectors++;
                if (d !== 24'h8BAC0F) begin
                    miscompares++;
                    $display("FAIL pix_gx8: got %h want 8bac0f", d);
                end
            end
            if (h == 0 && v == 30) begin
                vectors++;
                if (d !== 24'h000000) begin
                    miscompares++;
                    $display("FAIL pix_outside: got %h want 000000", d);
                end
            end
            if (de) begin de_total++; line_de++; end
            if (!hs) line_hs++;
            if (h == 0 && !vs) vs_lines++;
            if (h == 857) begin
                vectors++;
                if (line_de != ((v < 480) ? 720 : 0) || line_hs != 62) begin
                    miscompares++;
                    $display("FAIL line_counts v=%0d: got de=%0d hs_low=%0d want %0d 62",
                             v, line_de, line_hs, (v < 480) ? 720 : 0);
                end
                line_de = 0;
                line_hs = 0;
            end
            tick();
        end
        vectors++;
        if (de_total != 720 * 480 || vs_lines != 6) begin
            miscompares++;
            $display("FAIL frame_counts: got de=%0d vs_lines=%0d want 345600 6", de_total, vs_lines);
        end
        vectors++;
        if (de !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_period: de=%b at cycle 450450, want 1", de);
        end
        vectors++;
        if ({rA, rF, rH, rL} !== {8'h00, 8'h80, 16'h0001}) begin
            miscompares++;
            $display("FAIL idle_update: got A=%h F=%h HL=%h%h want 00 80 0001", rA, rF, rH, rL);
        end
    endtask

    // right held for five updates; start and a toggled; b/select randomised
    task automatic test_right_hold();
        for (int k = 0; k < 5; k++) begin
            btn = 8'h01;
            if (k == 0 || k == 2) btn[7] = 1'b1;
            if (k == 1 || k == 3) btn[4] = 1'b1;
            btn[6:5] = 2'($urandom_range(0, 3));
            run_to_update();
            tick();
            vectors++;
            if ({rA, rB, rC, rE, rF, rH, rL} !== {mA, mB, mC, mE, mF, mHL}) begin
                miscompares++;
                $display("FAIL right_hold k=%0d: got A=%h B=%h C=%h E=%h F=%h HL=%h%h want %h %h %h %h %h %h",
                         k, rA, rB, rC, rE, rF, rH, rL, mA, mB, mC, mE, mF, mHL);
            end
        end
        vectors++;
        if ({rC, rE, rB} !== {8'h05, 8'h02, 8'h02}) begin
            miscompares++;
            $display("FAIL right_totals: got C=%h E=%h B=%h want 05 02 02", rC, rE, rB);
        end
    endtask

    task automatic test_release();
        btn = 8'h00;
        run_to_update();
        tick();
        vectors++;
        if ({rA, rC, rF} !== {8'h00, mC, 8'h80}) begin
            miscompares++;
            $display("FAIL release: got A=%h C=%h F=%h want 00 %h 80", rA, rC, rF, mC);
        end
    endtask

    task automatic test_both_and_up();
        logic [7:0] c_before;
        c_before = rC;
        btn = 8'h07;
        run_to_update();
        tick();
        vectors++;
        if ({rC, rD, rA, rF} !== {c_before, 8'hFF, 8'h07, 8'h00}) begin
            miscompares++;
            $display("FAIL both_up: got C=%h D=%h A=%h F=%h want %h ff 07 00", rC, rD, rA, rF, c_before);
        end
    endtask

    task automatic test_random();
        btn = 8'($urandom);
        run_to_update();
        tick();
        vectors++;
        if ({rA, rB, rC, rD, rE, rF, rH, rL} !== {mA, mB, mC, mD, mE, mF, mHL}) begin
            miscompares++;
            $display("FAIL random btn=%h: got %h %h %h %h %h %h %h%h want %h %h %h %h %h %h %h",
                     btn, rA, rB, rC, rD, rE, rF, rH, rL, mA, mB, mC, mD, mE, mF, mHL);
        end
    endtask

    task automatic test_midframe_reset();
        btn = 8'h00;
        repeat (1000) tick();
        apply_reset();
        vectors++;
        if ({de, hs, vs, d, rA, rB, rC, rD, rE, rF, rH, rL} !==
            {1'b0, 1'b1, 1'b1, 24'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 16'h0000}) begin
            miscompares++;
            $display("FAIL midframe_reset: got de=%b hs=%b vs=%b d=%h regs %h %h %h %h %h %h %h%h",
                     de, hs, vs, d, rA, rB, rC, rD, rE, rF, rH, rL);
        end
        rst = 1'b0;
        t = -1;
        tick();
        vectors++;
        if ({de, d} !== {1'b1, 24'h0}) begin
            miscompares++;
            $display("FAIL restart_frame: got de=%b d=%h want 1 000000", de, d);
        end
    endtask

    initial begin
        pal[0] = 24'h9BBC0F;
        pal[1] = 24'h8BAC0F;
        pal[2] = 24'h306230;
        pal[3] = 24'h0F380F;
        model_reset();
        test_reset();
        test_frame();
        test_right_hold();
        test_release();
        test_both_and_up();
        test_random();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
